// File: rtl/gpio_hex_pkg.sv
// rtl/gpio_hex_pkg.sv - register map, CTRL field positions and active-low glyph table
package gpio_hex_pkg;

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_CTRL  = 2'd1;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_LZ_BIT    = 1;
  localparam int CTRL_BLINK_LSB = 8;
  localparam int CTRL_BLANK_LSB = 16;

  localparam logic [31:0] CTRL_RW_MASK = 32'h00FF_FF03;
  localparam logic [31:0] CTRL_RESET   = 32'h0000_0001;

  localparam logic [6:0] SEG_DARK = 7'h7F;

  // Glyph for nibble n sits at [7*n +: 7]; bit 0 = segment a, lowercase b and d.
  localparam logic [16*7-1:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - combinational nibble to active-low 7-segment decoder with blank
module hex_seg_decode
  import gpio_hex_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DARK;
    if (!blank) begin
      seg = GLYPH_TABLE[{3'b000, nibble} * 7'd7 +: 7];
    end
  end

endmodule

// File: rtl/gpio_hex_display.sv
// rtl/gpio_hex_display.sv - register-mapped multi-digit hex display with blink and zero suppression
module gpio_hex_display
  import gpio_hex_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [1:0]            addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [7*N_DIGITS-1:0] hex_seg,
  output logic                  blink_phase
);

  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [4*N_DIGITS-1:0] value_q, value_d;
  logic [31:0]           ctrl_q, ctrl_d;
  logic [CNT_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [7*N_DIGITS-1:0] hex_seg_q, hex_seg_d;

  logic                  wr_value, wr_ctrl;
  logic [N_DIGITS-1:0]   digit_blank;
  logic [7*N_DIGITS-1:0] seg_w;

  always_comb begin
    wr_value      = wr_en && (addr == ADDR_VALUE);
    wr_ctrl       = wr_en && (addr == ADDR_CTRL);
    value_d       = wr_value ? wr_data[4*N_DIGITS-1:0] : value_q;
    ctrl_d        = wr_ctrl ? (wr_data & CTRL_RW_MASK) : ctrl_q;
    blink_cnt_d   = blink_cnt_q + CNT_W'(1);
    blink_phase_d = blink_phase_q;
    // A CTRL write restarts the blink cycle even when it lands on a wrap.
    if (wr_ctrl) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = !blink_phase_q;
    end
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      case (addr)
        ADDR_VALUE: rd_data_d = 32'(value_q);
        ADDR_CTRL:  rd_data_d = ctrl_q;
        default:    rd_data_d = 32'h0;
      endcase
    end
  end

  always_comb begin
    logic upper_zero;
    upper_zero  = 1'b1;
    digit_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero     = upper_zero && (value_q[4*i +: 4] == 4'h0);
      digit_blank[i] = !ctrl_q[CTRL_EN_BIT]
                    || ctrl_q[CTRL_BLANK_LSB + i]
                    || (ctrl_q[CTRL_BLINK_LSB + i] && blink_phase_q)
                    || (ctrl_q[CTRL_LZ_BIT] && (i > 0) && upper_zero);
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    hex_seg_decode u_dec (
      .nibble (value_q[4*g +: 4]),
      .blank  (digit_blank[g]),
      .seg    (seg_w[7*g +: 7])
    );
  end

  always_comb begin
    hex_seg_d = seg_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q       <= '0;
      ctrl_q        <= CTRL_RESET;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      hex_seg_q     <= '1;
    end else begin
      value_q       <= value_d;
      ctrl_q        <= ctrl_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      hex_seg_q     <= hex_seg_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign hex_seg     = hex_seg_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// tb/tb_gpio_hex_display.sv - self-checking bench for gpio_hex_display
module tb_gpio_hex_display;

  localparam int ND = 8;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   wr_data = 32'h0;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [7*ND-1:0] hex_seg;
  logic          blink_phase;

  gpio_hex_display #(.N_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .hex_seg     (hex_seg),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0]    glyph_hi [16];
  logic [31:0]   m_value;
  logic [31:0]   m_ctrl;
  int            m_ticks;
  logic [7*ND-1:0] e_seg;
  logic          e_valid;
  logic [31:0]   e_rd;

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_phase();
    return ((m_ticks / BD) % 2) == 1;
  endfunction

  function automatic logic [7*ND-1:0] model_display();
    logic [7*ND-1:0] r;
    logic [6:0] d;
    int nib;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      nib = int'((m_value >> (4 * i)) & 32'hF);
      if (!m_ctrl[0])                                   d = 7'h7F;
      else if (m_ctrl[16 + i])                          d = 7'h7F;
      else if (m_ctrl[8 + i] && model_phase())          d = 7'h7F;
      else if (m_ctrl[1] && i > 0 && (m_value >> (4 * i)) == 0) d = 7'h7F;
      else                                              d = ~glyph_hi[nib];
      r[7*i +: 7] = d;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_value = 32'h0;
    m_ctrl  = 32'h1;
    m_ticks = 0;
    e_seg   = '1;
    e_valid = 1'b0;
    e_rd    = 32'h0;
  endtask

  task automatic step(input logic we, input logic re, input logic [1:0] a, input logic [31:0] wd);
    wr_en = we; rd_en = re; addr = a; wr_data = wd;
    @(posedge clk);
    e_seg   = model_display();
    e_valid = re;
    if (re) e_rd = (a == 2'd0) ? m_value : (a == 2'd1) ? m_ctrl : 32'h0;
    if (we && a == 2'd0) m_value = wd;
    if (we && a == 2'd1) begin
      m_ctrl  = wd & 32'h00FF_FF03;
      m_ticks = 0;
    end else begin
      m_ticks++;
    end
    #1;
    check("hex_seg", 64'(hex_seg), 64'(e_seg));
    check("blink_phase", 64'(blink_phase), 64'(model_phase()));
    check("rd_valid", 64'(rd_valid), 64'(e_valid));
    if (e_valid) check("rd_data", 64'(rd_data), 64'(e_rd));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  initial begin
    logic [1:0]  ra;
    logic [31:0] rw;
    logic        rwe;
    glyph_hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_1234, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 32'h0000_5678, 1'b1, 32'h0000_1234};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_5678};
    vecs[3]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h0000_0001};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_5678};
    vecs[6]  = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h00FF_FF03};
    vecs[8]  = '{1'b1, 1'b0, 2'd1, 32'h0,         1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h0};

    model_reset();
    #12;
    check("reset_hex_seg", 64'(hex_seg), 64'({7*ND{1'b1}}));
    check("reset_rd_valid", 64'(rd_valid), 64'h0);
    check("reset_rd_data", 64'(rd_data), 64'h0);
    check("reset_blink_phase", 64'(blink_phase), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    step(1'b0, 1'b1, 2'd1, 32'h0);
    check("post_reset_zeros", 64'(hex_seg), 64'({ND{7'h40}}));
    idle(1);
    check("post_reset_ctrl_rd", 64'(rd_data), 64'h1);

    for (int v = 0; v < 11; v++) begin
      step(vecs[v].we, vecs[v].re, vecs[v].a, vecs[v].wd);
      if (vecs[v].chk) check($sformatf("vec%0d_rd_data", v), 64'(rd_data), 64'(vecs[v].exp_rd));
    end
    idle(1);
    check("disabled_all_dark", 64'(hex_seg), 64'({ND{7'h7F}}));

    step(1'b1, 1'b0, 2'd0, 32'h0000_0A3F);
    step(1'b1, 1'b0, 2'd1, 32'h0000_0003);
    idle(1);
    check("lz_a3f", 64'(hex_seg), 64'({{5{7'h7F}}, 7'h08, 7'h30, 7'h0E}));

    step(1'b1, 1'b0, 2'd0, 32'h0);
    idle(1);
    check("lz_zero", 64'(hex_seg), 64'({{7{7'h7F}}, 7'h40}));

    step(1'b1, 1'b0, 2'd1, 32'h0000_0101);
    check("blink_restart_phase", 64'(blink_phase), 64'h0);
    for (int j = 1; j <= 12; j++) begin
      idle(1);
      check($sformatf("blink_digit0_%0d", j), 64'(hex_seg[6:0]),
            64'((((j - 1) / BD) % 2 == 1) ? 7'h7F : 7'h40));
    end
    idle(2);
    step(1'b1, 1'b0, 2'd1, 32'h0000_0101);
    check("mid_period_restart", 64'(blink_phase), 64'h0);
    idle(3);
    step(1'b1, 1'b0, 2'd1, 32'h0000_0101);
    check("wrap_vs_ctrl_write", 64'(blink_phase), 64'h0);
    idle(5);
    check("phase_before_reset", 64'(blink_phase), 64'h1);

    step(1'b0, 1'b1, 2'd0, 32'h0);
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midread_rd_valid", 64'(rd_valid), 64'h0);
    check("midread_phase", 64'(blink_phase), 64'h0);
    check("midread_hex_seg", 64'(hex_seg), 64'({7*ND{1'b1}}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    check("rerelease_zeros", 64'(hex_seg), 64'({ND{7'h40}}));

    for (int r = 0; r < 400; r++) begin
      rwe = 1'($urandom % 2);
      ra  = 2'($urandom_range(0, 3));
      rw  = $urandom;
      if (rwe && ra == 2'd1) begin
        if ($urandom % 8 != 0) ra = 2'd0;
        else rw[0] = ($urandom % 4 != 0);
      end
      step(rwe, 1'($urandom % 2), ra, rw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_hex_display.md
GPIO_HEX_DISPLAY -- requirements
Module: gpio_hex_display

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of 7-segment digits, legal range 1..8.
REQ-002 SHALL have parameter BLINK_DIV, default 25_000_000, clk cycles per blink half-period, legal range >= 2.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk and rst_n; there are no other clocks or resets.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_en  input  1  write strobe, one transfer per cycle while high.
REQ-007 rd_en  input  1  read strobe.
REQ-008 addr  input  2  register select: 0 = VALUE, 1 = CTRL, 2..3 = unmapped.
REQ-009 wr_data  input  32  write data.
REQ-010 rd_data  output  32  registered read data.
REQ-011 rd_valid  output  1  high for one cycle when rd_data is valid.
REQ-012 hex_seg  output  7*N_DIGITS  active-low segments; digit i occupies [7*i+6:7*i]; bit 0 = segment a ... bit 6 = segment g.
REQ-013 blink_phase  output  1  current blink phase; 1 = blinked digits are dark.

Function
REQ-014 SHALL load VALUE = wr_data[4*N_DIGITS-1:0] on a wr_en edge with addr 0; nibble i drives digit i.
REQ-015 SHALL load CTRL from wr_data on a wr_en edge with addr 1, using these fields:
- bit 0: enable
- bit 1: leading-zero suppress (lz)
- [15:8]: blink_mask
- [23:16]: blank_mask
- all other bits: read 0
REQ-016 SHALL ignore writes to addr 2 or 3.
REQ-017 SHALL ignore mask bits at or above N_DIGITS.
REQ-018 SHALL register hex_seg, so a write on edge k becomes visible on hex_seg at edge k+1 (latency 1).
REQ-019 SHALL determine each digit's output with this priority, highest first:
- enable = 0: all digits dark (7'h7F).
- blank_mask[i] = 1: digit i dark.
- blink_mask[i] = 1 and blink_phase = 1: digit i dark.
- lz suppression active on digit i: digit i dark.
- otherwise: hex glyph of the nibble, 0-F with lowercase b and d.
REQ-020 SHALL, with lz = 1, blank digit i when i > 0 and all nibbles from N_DIGITS-1 down to i are zero.
REQ-021 SHALL never suppress digit 0 for leading zeros, so VALUE = 0 shows a single "0".
REQ-022 SHALL count blink_cnt from 0 to BLINK_DIV-1; on wrap it SHALL toggle blink_phase and return to 0.
REQ-023 SHALL run blink_cnt regardless of enable.
REQ-024 SHALL, on any CTRL write, clear blink_cnt to 0 and blink_phase to 0 on the same edge.
REQ-025 SHALL, for rd_en at edge k, present rd_data and assert rd_valid at edge k+1:
- addr 0: VALUE zero-extended to 32 bits.
- addr 1: CTRL with unused bits 0.
- addr 2..3: 0.
REQ-026 SHALL, for rd_en and wr_en to the same addr in the same cycle, return the pre-write contents.
REQ-027 SHALL deassert rd_valid in every cycle that does not follow an rd_en.
REQ-028 SHALL, when a write and a blink wrap coincide, apply both on the same edge; a CTRL write's clear takes precedence over the toggle.

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously force these values:
- VALUE = 0
- CTRL = 32'h0000_0001
- blink_cnt = 0, blink_phase = 0
- rd_data = 0, rd_valid = 0
- hex_seg = all ones
REQ-030 SHALL show "0" on every digit at the first clk edge after rst_n rises.
REQ-031 SHALL, when reset is asserted mid-blink or mid-read, drop any pending rd_valid and restart the blink cycle from phase 0.

Structure
REQ-032 SHALL place CTRL field bit positions, register address constants and the 16-entry active-low glyph table in shared package gpio_hex_pkg.
REQ-033 SHALL instantiate one sub-module per digit, hex_seg_decode: 4-bit nibble plus blank input, combinational 7-bit active-low output.
REQ-034 SHALL keep all state (VALUE, CTRL, blink counter, read register, output register) in gpio_hex_display.

Verification
REQ-035 Reset release, no writes -> next edge hex_seg = N_DIGITS copies of 7'h40; rd addr 1 returns 32'h1 with rd_valid one cycle later.
REQ-036 Write VALUE = 32'h0000_0A3F, CTRL = 32'h3 (N_DIGITS = 8) -> digits 0..2 show F, 3, A; digits 3..7 = 7'h7F.
REQ-037 VALUE = 0 with lz = 1 -> only digit 0 lit, showing 7'h40.
REQ-038 BLINK_DIV = 4, CTRL = 32'h0000_0101 -> digit 0 alternates lit/dark every 4 cycles; a mid-period CTRL write restarts the phase at 0.
REQ-039 Same-cycle wr_en and rd_en to addr 0, old value 32'h1234 -> rd_data = 32'h1234; next read returns the new value.
REQ-040 Write to addr 2 and CTRL enable = 0 -> VALUE and CTRL unchanged by the addr 2 write; read of addr 2 returns 0; all digits dark with enable = 0.
